// File: rtl/change_pkg.sv
// Shared types and coin codes for the change dispenser slice.
package change_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ITEM,
    PICK,
    ISSUE,
    FIN
  } state_t;

  localparam int unsigned NCOIN = 4;

  localparam logic [1:0] C50 = 2'd0;
  localparam logic [1:0] C10 = 2'd1;
  localparam logic [1:0] C5  = 2'd2;
  localparam logic [1:0] C1  = 2'd3;

endpackage

// File: rtl/coin_picker.sv
// Greedy coin chooser: lowest code (largest value) that fits rem and is available.
module coin_picker
  import change_pkg::*;
(
  input  logic [7:0]             rem,
  input  logic [NCOIN-1:0][7:0]  vals,
  input  logic [NCOIN-1:0]       avail,
  output logic [1:0]             code,
  output logic                   found
);

  always_comb begin
    code  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCOIN; i++) begin
      if (!found && avail[i] && (vals[i] <= rem)) begin
        code  = i[1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Vends the item code, then pays change greedily one coin at a time over valid/ack.
// Optional COIN_INV_EN: per-denomination inventory with shortfall reporting.
module change_dispenser
  import change_pkg::*;
#(
  parameter int unsigned VAL0     = 50,
  parameter int unsigned VAL1     = 10,
  parameter int unsigned VAL2     = 5,
  parameter int unsigned VAL3     = 1,
  parameter int unsigned INV_INIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] MO,
  input  logic [1:0] PO,
  output logic       item_vld,
  output logic [1:0] item_id,
  output logic       coin_vld,
  output logic [1:0] coin_sel,
  input  logic       coin_ack,
  output logic       busy,
  output logic       done,
  output logic       req_drop,
  output logic       short_flg,
  output logic [7:0] short_amt
);

  state_t                state, state_n;
  logic [7:0]            rem, rem_n;
  logic [1:0]            id_n, sel_n;
  logic                  drop_n;
  logic                  accept;
  logic [NCOIN-1:0][7:0] vals;
  logic [NCOIN-1:0]      avail;
  logic [1:0]            pick_code;
  logic                  found;

  assign vals   = {8'(VAL3), 8'(VAL2), 8'(VAL1), 8'(VAL0)};
  assign accept = coin_vld && coin_ack;

  coin_picker u_picker (
    .rem   (rem),
    .vals  (vals),
    .avail (avail),
    .code  (pick_code),
    .found (found)
  );

  always_comb begin
    state_n = state;
    rem_n   = rem;
    id_n    = item_id;
    sel_n   = coin_sel;
    drop_n  = req_drop;
    if ((PO != '0) && (state != IDLE))
      drop_n = 1'b1;
    unique case (state)
      IDLE: begin
        if (PO != '0) begin
          state_n = ITEM;
          rem_n   = MO;
          id_n    = PO;
        end
      end
      ITEM: state_n = PICK;
      PICK: begin
        if (rem == '0)
          state_n = FIN;
        else if (found) begin
          state_n = ISSUE;
          sel_n   = pick_code;
        end else
          state_n = FIN;
      end
      ISSUE: begin
        if (accept) begin
          rem_n   = rem - vals[coin_sel];
          state_n = PICK;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      item_id  <= '0;
      coin_sel <= '0;
      req_drop <= 1'b0;
      item_vld <= 1'b0;
      coin_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      item_id  <= id_n;
      coin_sel <= sel_n;
      req_drop <= drop_n;
      item_vld <= (state_n == ITEM);
      coin_vld <= (state_n == ISSUE);
      busy     <= (state_n != IDLE);
      done     <= (state_n == FIN);
    end
  end

`ifdef COIN_INV_EN
  logic [NCOIN-1:0][7:0] inv;

  always_comb begin
    for (int unsigned i = 0; i < NCOIN; i++)
      avail[i] = (inv[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCOIN; i++)
        inv[i] <= 8'(INV_INIT);
      short_flg <= 1'b0;
      short_amt <= '0;
    end else begin
      if (accept)
        inv[coin_sel] <= inv[coin_sel] - 8'd1;
      // Shortfall is only possible on the PICK -> FIN path with change still owed.
      short_flg <= (state == PICK) && (rem != '0) && !found;
      short_amt <= ((state == PICK) && (rem != '0) && !found) ? rem : '0;
    end
  end
`else
  logic unused_inv_init;

  assign unused_inv_init = |INV_INIT;
  assign avail           = '1;
  assign short_flg       = 1'b0;
  assign short_amt       = '0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a greedy-change scoreboard (honours COIN_INV_EN).
module tb_change_dispenser;

  localparam int unsigned INV_INIT = 1;
  localparam int VALS [4] = '{50, 10, 5, 1};
`ifdef COIN_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef struct packed {
    logic       s;
    logic [7:0] a;
  } done_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] MO;
  logic [1:0] PO;
  logic       item_vld;
  logic [1:0] item_id;
  logic       coin_vld;
  logic [1:0] coin_sel;
  logic       coin_ack;
  logic       busy;
  logic       done;
  logic       req_drop;
  logic       short_flg;
  logic [7:0] short_amt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [1:0] exp_item [$];
  logic [1:0] exp_coin [$];
  done_t      exp_done [$];
  int         m_inv [4];

  change_dispenser #(
    .VAL0     (50),
    .VAL1     (10),
    .VAL2     (5),
    .VAL3     (1),
    .INV_INIT (INV_INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MO        (MO),
    .PO        (PO),
    .item_vld  (item_vld),
    .item_id   (item_id),
    .coin_vld  (coin_vld),
    .coin_sel  (coin_sel),
    .coin_ack  (coin_ack),
    .busy      (busy),
    .done      (done),
    .req_drop  (req_drop),
    .short_flg (short_flg),
    .short_amt (short_amt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_inv[i] = INV_INIT;
  endtask

  // Greedy largest-first payout, skipping empty denominations when inventory is tracked.
  task automatic expect_sale(input logic [1:0] po, input logic [7:0] mo);
    logic [7:0] r;
    bit hit;
    done_t d;
    r = mo;
    exp_item.push_back(po);
    do begin
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!hit && r != 0 && VALS[i] <= int'(r) && (!INV_EN || m_inv[i] != 0)) begin
          hit = 1'b1;
          exp_coin.push_back(2'(i));
          r = r - 8'(VALS[i]);
          if (INV_EN) m_inv[i] = m_inv[i] - 1;
        end
      end
    end while (hit);
    d.s = INV_EN && (r != 0);
    d.a = INV_EN ? r : 8'd0;
    exp_done.push_back(d);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic sale(input logic [1:0] po, input logic [7:0] mo);
    @(posedge clk); #1 PO = po; MO = mo;
    @(posedge clk); #1 PO = 2'd0;
  endtask

  task automatic wait_done(input int unsigned budget);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_coin(input int unsigned budget);
    bit seen;
    seen = coin_vld;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (coin_vld) seen = 1'b1;
    end
    if (!seen) chk("coin_timeout", 32'(seen), 32'd1);
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (item_vld) begin
        if (exp_item.size() == 0) chk("item_unexpected", exp_item.size(), 32'd1);
        else chk("item_id", item_id, exp_item.pop_front());
      end
      if (coin_vld && coin_ack) begin
        if (exp_coin.size() == 0) chk("coin_unexpected", exp_coin.size(), 32'd1);
        else chk("coin_sel", coin_sel, exp_coin.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", exp_done.size(), 32'd1);
        else begin
          done_t d;
          d = exp_done.pop_front();
          chk("short_flg", short_flg, d.s);
          chk("short_amt", short_amt, d.a);
        end
      end
    end
  end

  initial begin
    logic [1:0] c0;
    rst = 1'b1; PO = '0; MO = '0; coin_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_coin_vld", coin_vld, 1'b0);
    chk("rst_item_vld", item_vld, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req_drop", req_drop, 1'b0);
    chk("rst_item_id", item_id, 2'd0);
    chk("rst_short_amt", short_amt, 8'd0);

    // 1: PO=2, MO=67, ack always high
    coin_ack = 1'b1;
    expect_sale(2'd2, 8'd67);
    sale(2'd2, 8'd67);
    chk("t1_item_lat", item_vld, 1'b1);
    chk("t1_busy", busy, 1'b1);
    @(posedge clk); #1 chk("t1_pick_no_coin", coin_vld, 1'b0);
    @(posedge clk); #1 chk("t1_coin_lat", coin_vld, 1'b1);
    wait_done(40);

    // 2: MO=0 -> done two cycles after item_vld, no coin
    expect_sale(2'd1, 8'd0);
    sale(2'd1, 8'd0);
    chk("t2_item", item_vld, 1'b1);
    @(posedge clk); #1 chk("t2_pick_done", done, 1'b0);
    @(posedge clk); #1 chk("t2_done", done, 1'b1);
    chk("t2_no_coin", coin_vld, 1'b0);

    // 3: hopper stalls, coin_sel must hold
    do_reset();
    coin_ack = 1'b0;
    expect_sale(2'd1, 8'd15);
    c0 = exp_coin[0];
    sale(2'd1, 8'd15);
    wait_coin(10);
    repeat (5) begin
      chk("t3_vld_hold", coin_vld, 1'b1);
      chk("t3_sel_hold", coin_sel, c0);
      @(posedge clk); #1;
    end
    coin_ack = 1'b1;
    wait_done(40);

    // 4: request while busy is dropped and flagged
    do_reset();
    expect_sale(2'd2, 8'd11);
    @(posedge clk); #1 PO = 2'd2; MO = 8'd11;
    @(posedge clk); #1 PO = 2'd3; MO = 8'd99;
    @(posedge clk); #1 PO = 2'd0;
    chk("t4_drop", req_drop, 1'b1);
    wait_done(40);
    chk("t4_drop_sticky", req_drop, 1'b1);

    // 5: reset while a coin is pending
    coin_ack = 1'b0;
    exp_item.push_back(2'd1);
    sale(2'd1, 8'd15);
    wait_coin(10);
    chk("t5_drop_before", req_drop, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    chk("t5_coin_vld", coin_vld, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_req_drop", req_drop, 1'b0);
    chk("t5_item_id", item_id, 2'd0);
    @(posedge clk); #1 chk("t5_stay_idle", busy, 1'b0);

    // 6: MO=20 (shortfall when inventory is one coin each)
    coin_ack = 1'b1;
    expect_sale(2'd2, 8'd20);
    sale(2'd2, 8'd20);
    wait_done(40);

    repeat (3) @(posedge clk);
    #1;
    chk("item_q_empty", exp_item.size(), 32'd0);
    chk("coin_q_empty", exp_coin.size(), 32'd0);
    chk("done_q_empty", exp_done.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
